ohm_div_mc: RTL

//  Multi-channel, parametrised igniter-resistance divider: R = V*SCALE/I, computed by one shared

---
 rtl/ohm_div_mc.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ohm_div_mc.sv
// Multi-channel igniter-resistance divider: R = V*SCALE/I.
// One shared radix-4 restoring divider produces 2 quotient bits per cycle.
// Results are emitted as a tagged one-cycle pulse and latched per channel.
module ohm_div_mc #(
   parameter int N_CH     = 4,
   parameter int ADC_W    = 12,
   parameter int SCALE    = 42089,
   parameter int OUT_W    = 12,
   parameter int OUT_FRAC = 5,
   parameter int I_MIN    = 32,
   localparam int CH_W    = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH_W-1:0]       in_ch,
   input  logic [ADC_W-1:0]      v_in,
   input  logic [ADC_W-1:0]      i_in,
   output logic                  out_valid,
   output logic [CH_W-1:0]       out_ch,
   output logic [OUT_W-1:0]      out_r,
   output logic                  out_lowi,
   output logic [N_CH*OUT_W-1:0] r_hold
);

   localparam int M       = ADC_W - 1;
   localparam int NUM_W   = M + 16;
   localparam int Q_W     = NUM_W + 3;
   localparam int DIV_CYC = (Q_W + 1) / 2;
   localparam int QP_W    = 2 * DIV_CYC;     // quotient padded to an even bit count
   localparam int R_W     = M + 3;           // width of the shifted partial remainder
   localparam int SHIFT   = 13 - OUT_FRAC;
   localparam int CNT_W   = $clog2(DIV_CYC);

   // ADC-format zero: sign clear, inverted magnitude all ones
   localparam logic [OUT_W-1:0] ZERO_ENC = {1'b0, {(OUT_W-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [QP_W-1:0]         dvd_q, dvd_d;
   logic [QP_W-1:0]         quo_q, quo_d;
   logic [R_W-3:0]          rem_q, rem_d;
   logic [R_W-1:0]          d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic                    lowi_q, lowi_d;
   logic [CH_W-1:0]         out_ch_q, out_ch_d;
   logic [OUT_W-1:0]        out_r_q, out_r_d;
   logic                    out_lowi_q, out_lowi_d;
   logic [N_CH*OUT_W-1:0]   r_hold_q, r_hold_d;

   logic [M-1:0]            v_dec, i_dec;
   logic [NUM_W-1:0]        num;
   logic [R_W-1:0]          i_ext;
   logic [R_W-1:0]          t;
   logic [1:0]              digit;
   logic [R_W-3:0]          rem_nxt;
   logic [QP_W-1:0]         quo_nxt;
   logic [OUT_W-1:0]        r_new;

   // Negative voltage reads as zero; inverted magnitude bits
   function automatic logic [M-1:0] dec_v(input logic [ADC_W-1:0] x);
      if (x[ADC_W-1]) return '0;
      return x[M-1:0] ^ {M{1'b1}};
   endfunction

   // Negative or zero current is clamped to 1 so the divisor is never zero
   function automatic logic [M-1:0] dec_i(input logic [ADC_W-1:0] x);
      if (x[ADC_W-1] || (x[M-1:0] == {M{1'b1}})) return M'(1);
      return x[M-1:0] ^ {M{1'b1}};
   endfunction

   // Drop extra fractional bits and saturate to the output magnitude range
   function automatic logic [OUT_W-2:0] sat_mag(input logic [QP_W-1:0] q);
      logic [QP_W-1:0] s;
      s = q >> SHIFT;
      if (s > QP_W'((2 ** (OUT_W - 1)) - 1)) return '1;
      return s[OUT_W-2:0];
   endfunction

   // One radix-4 step: pick the largest multiple of I that fits
   always_comb begin
      t       = {rem_q, dvd_q[QP_W-1 -: 2]};
      digit   = 2'd0;
      rem_nxt = rem_q;
      if (t >= d3_q) begin
         digit   = 2'd3;
         rem_nxt = (R_W-2)'(t - d3_q);
      end else if (t >= d2_q) begin
         digit   = 2'd2;
         rem_nxt = (R_W-2)'(t - d2_q);
      end else if (t >= d1_q) begin
         digit   = 2'd1;
         rem_nxt = (R_W-2)'(t - d1_q);
      end else begin
         rem_nxt = (R_W-2)'(t);
      end
      quo_nxt = (quo_q << 2) | QP_W'(digit);
      r_new   = lowi_q ? ZERO_ENC : {1'b0, sat_mag(quo_nxt) ^ {(OUT_W-1){1'b1}}};
   end

   // Next-state, operand capture and result/hold update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      d1_d       = d1_q;
      d2_d       = d2_q;
      d3_d       = d3_q;
      ch_d       = ch_q;
      lowi_d     = lowi_q;
      out_ch_d   = out_ch_q;
      out_r_d    = out_r_q;
      out_lowi_d = out_lowi_q;
      r_hold_d   = r_hold_q;
      v_dec      = dec_v(v_in);
      i_dec      = dec_i(i_in);
      num        = NUM_W'(v_dec) * NUM_W'(SCALE);
      i_ext      = R_W'(i_dec);
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_DIV;
               cnt_d   = '0;
               dvd_d   = QP_W'({num, 3'b000});
               quo_d   = '0;
               rem_d   = '0;
               d1_d    = i_ext;
               d2_d    = i_ext << 1;
               d3_d    = i_ext + (i_ext << 1);
               ch_d    = in_ch;
               lowi_d  = (32'(i_dec) <= I_MIN);
            end
         end
         S_DIV: begin
            dvd_d = dvd_q << 2;
            quo_d = quo_nxt;
            rem_d = rem_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_CYC - 1)) begin
               state_d    = S_OUT;
               out_ch_d   = ch_q;
               out_r_d    = r_new;
               out_lowi_d = lowi_q;
               if (32'(ch_q) < N_CH) r_hold_d[int'(ch_q)*OUT_W +: OUT_W] = r_new;
            end
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control and visible result registers, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         out_ch_q   <= '0;
         out_r_q    <= ZERO_ENC;
         out_lowi_q <= 1'b0;
         r_hold_q   <= {N_CH{ZERO_ENC}};
      end else begin
         state_q    <= state_d;
         out_ch_q   <= out_ch_d;
         out_r_q    <= out_r_d;
         out_lowi_q <= out_lowi_d;
         r_hold_q   <= r_hold_d;
      end
   end

   // Divider datapath registers, only meaningful while a division is running
   always_ff @(posedge clk) begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      d3_q   <= d3_d;
      ch_q   <= ch_d;
      lowi_q <= lowi_d;
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign out_ch    = out_ch_q;
   assign out_r     = out_r_q;
   assign out_lowi  = out_lowi_q;
   assign r_hold    = r_hold_q;

endmodule
